sd_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer placed in front of the SD-card SPI controller. It accepts single-block read and write requests from two independent clients, grants the controller to one at a time using round-robin, and issues the one-cycle `rd`/`wr` command with the address. For the duration of the block it routes the byte stream between controller and owner, then reports completion. The block sits between the system-side DMA/CPU clients and the SD controller's `rd/wr/ain/ready/dout/din` interface.

---
 rtl/sd_arbiter.sv | 143 ++++++++++++++
 tb/tb_sd_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_arbiter.sv
// sd_arbiter: two-client round-robin arbiter and single-block transaction
// sequencer in front of the SD-card SPI controller.
// Optional feature: define SD_ARB_TIMEOUT_EN to enable the busy watchdog (err).
module sd_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic [1:0]  gnt,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  wdata_ready,
  output logic [7:0]  rdata,
  output logic [1:0]  rdata_valid,
  output logic [1:0]  done,
  output logic        err,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_ain,
  input  logic        sd_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_valid,
  output logic [7:0]  sd_din,
  input  logic        sd_din_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   last;   // index of the client granted most recently
  logic   dir;    // latched direction of the current transaction, 1 = write
  logic   win;    // winning client index for this IDLE cycle
  logic   grant;  // a grant is made this cycle

  // Winner selection: a lone requester wins, a tie goes to the client not granted last
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign grant = (state == IDLE) && sd_ready && (req != 2'b00);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (grant) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: if (!sd_ready) state_nxt = BUSY;
      BUSY:       if (sd_ready) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Registered grant, command, address, completion and round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt    <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      sd_ain <= '0;
      done   <= '0;
      dir    <= 1'b0;
      last   <= 1'b1;
    end else begin
      // Command pulse is registered off ISSUE so it lands two cycles after the request sample
      sd_rd <= (state == ISSUE) && !dir;
      sd_wr <= (state == ISSUE) && dir;
      done  <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            gnt    <= win ? 2'b10 : 2'b01;
            sd_ain <= win ? addr1 : addr0;
            dir    <= we[win];
          end
        end
        BUSY: begin
          if (sd_ready) done <= gnt;
        end
        DONE: begin
          last <= gnt[1];
          gnt  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] cnt;

  // Busy watchdog: counts WAIT_START/BUSY cycles, saturates, sets a sticky err
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (grant) err <= 1'b0;
      case (state)
        ISSUE: cnt <= '0;
        WAIT_START, BUSY: begin
          if (cnt != TIMEOUT) cnt <= cnt + 32'd1;
          if (cnt == TIMEOUT - 32'd1) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  // Byte-stream routing between the controller and the owning client
  always_comb begin
    sd_din      = gnt[1] ? wdata1 : wdata0;
    rdata       = sd_dout;
    wdata_ready = '0;
    rdata_valid = '0;
    if (state == BUSY) begin
      if (dir) wdata_ready = gnt & {2{sd_din_ready}};
      else     rdata_valid = gnt & {2{sd_dout_valid}};
    end
  end

endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter: directed scoreboard bench for sd_arbiter; the bench plays
// both clients and the SD controller.
module tb_sd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [31:0] addr0, addr1;
  logic [1:0]  gnt;
  logic [7:0]  wdata0, wdata1;
  logic [1:0]  wdata_ready;
  logic [7:0]  rdata;
  logic [1:0]  rdata_valid;
  logic [1:0]  done;
  logic        err;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_ain;
  logic        sd_ready;
  logic [7:0]  sd_dout;
  logic        sd_dout_valid;
  logic [7:0]  sd_din;
  logic        sd_din_ready;

  sd_arbiter #(.TIMEOUT(32'd100)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .wdata0(wdata0), .wdata1(wdata1), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ain(sd_ain), .sd_ready(sd_ready),
    .sd_dout(sd_dout), .sd_dout_valid(sd_dout_valid), .sd_din(sd_din),
    .sd_din_ready(sd_din_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          client;
    bit          wr;
    logic [31:0] addr;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] wexp0, wexp1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Grant must never be two-hot
  always @(negedge clock) begin
    if (!reset) chk("gnt_onehot", {31'd0, gnt == 2'b11}, 32'd0);
  end

  // Plays the controller for one transaction whose request is pending in IDLE now
  task automatic serve(input int nbytes);
    txn_t e;
    logic [1:0] own;
    logic [7:0] b;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e   = exp_q.pop_front();
    own = (e.client == 1) ? 2'b10 : 2'b01;
    step();
    chk("gnt", {30'd0, gnt}, {30'd0, own});
    req[e.client] = 1'b0;
    step();
    chk("sd_rd", {31'd0, sd_rd}, {31'd0, !e.wr});
    chk("sd_wr", {31'd0, sd_wr}, {31'd0, e.wr});
    chk("sd_ain", sd_ain, e.addr);
    sd_ready = 1'b0;
    step();
    chk("cmd_once", {30'd0, sd_rd, sd_wr}, 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      if (e.wr) begin
        sd_din_ready = 1'b1;
        #1;
        chk("wdata_ready", {30'd0, wdata_ready}, {30'd0, own});
        chk("sd_din", {24'd0, sd_din}, {24'd0, (e.client == 1) ? wexp1 : wexp0});
        step();
        if (e.client == 1) begin wdata1 = wdata1 + 8'd1; wexp1 = wexp1 + 8'd1; end
        else               begin wdata0 = wdata0 + 8'd1; wexp0 = wexp0 + 8'd1; end
        sd_din_ready = 1'b0;
        #1;
        chk("wdata_ready_idle", {30'd0, wdata_ready}, 32'd0);
      end else begin
        b = 8'($urandom);
        sd_dout = b;
        sd_dout_valid = 1'b1;
        #1;
        chk("rdata_valid", {30'd0, rdata_valid}, {30'd0, own});
        chk("rdata", {24'd0, rdata}, {24'd0, b});
        step();
        sd_dout_valid = 1'b0;
        #1;
        chk("rdata_valid_idle", {30'd0, rdata_valid}, 32'd0);
      end
      step();
    end
    sd_ready = 1'b1;
    step();
    chk("done", {30'd0, done}, {30'd0, own});
    step();
    chk("done_clear", {30'd0, done}, 32'd0);
    chk("gnt_clear", {30'd0, gnt}, 32'd0);
    chk("err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; wexp0 = '0; wexp1 = '0;
    sd_ready = 1'b1; sd_dout = '0; sd_dout_valid = 1'b0; sd_din_ready = 1'b0;
    step();
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_cmd", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("rst_ain", sd_ain, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Client 0 single-block read
    addr0 = 32'h0000_0010; we[0] = 1'b0; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 32'h0000_0010});
    serve(4);

    // Client 1 write, bytes wrapping through 8'hFF
    addr1 = 32'h0000_2000; we[1] = 1'b1; req[1] = 1'b1;
    exp_q.push_back('{1, 1'b1, 32'h0000_2000});
    serve(300);

    // Round-robin ties after a fresh reset: 0, 1, 0, then the leftover 1
    reset = 1'b1;
    step();
    reset = 1'b0;
    we = 2'b00; addr0 = 32'h0000_0100; addr1 = 32'h0000_0200; req = 2'b11;
    exp_q.push_back('{0, 1'b0, 32'h0000_0100});
    serve(2);
    req[0] = 1'b1;
    exp_q.push_back('{1, 1'b0, 32'h0000_0200});
    serve(2);
    req[1] = 1'b1;
    exp_q.push_back('{0, 1'b0, 32'h0000_0100});
    serve(2);
    exp_q.push_back('{1, 1'b0, 32'h0000_0200});
    serve(2);

    // Controller not ready: request stays pending
    sd_ready = 1'b0;
    addr0 = 32'h0000_0030; we[0] = 1'b0; req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gnt_hold", {30'd0, gnt}, 32'd0);
    end
    sd_ready = 1'b1;
    exp_q.push_back('{0, 1'b0, 32'h0000_0030});
    serve(2);

    // Reset in the middle of BUSY
    addr0 = 32'h0000_0040; req[0] = 1'b1;
    step();
    chk("mid_gnt", {30'd0, gnt}, 32'd1);
    req[0] = 1'b0;
    step();
    sd_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    chk("mid_rst_cmd", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("mid_rst_done", {30'd0, done}, 32'd0);
    step();
    reset = 1'b0;
    sd_ready = 1'b1;
    addr0 = 32'h0000_0044; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 32'h0000_0044});
    serve(3);

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog: controller stuck busy for 150 cycles
    addr1 = 32'h0000_0099; we[1] = 1'b0; req[1] = 1'b1;
    step();
    chk("to_gnt", {30'd0, gnt}, 32'd2);
    req[1] = 1'b0;
    step();
    sd_ready = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      chk("to_err_early", {31'd0, err}, 32'd0);
      step();
    end
    chk("to_err_set", {31'd0, err}, 32'd1);
    for (int i = 0; i < 49; i++) step();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    sd_ready = 1'b1;
    step();
    chk("to_done", {30'd0, done}, 32'd2);
    step();
    chk("to_err_idle", {31'd0, err}, 32'd1);
    addr0 = 32'h0000_0050; we[0] = 1'b0; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 32'h0000_0050});
    serve(1);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
